ps2_key_event_ctrl: RTL and testbench

//  Sequences raw PS/2 scan-code bytes from the PS/2 receiver into key events.

---
 rtl/ps2_pkg.sv | 32 +++
 rtl/ps2_event_fifo.sv | 44 ++++
 rtl/ps2_key_event_ctrl.sv | 160 ++++++++++++++++
 tb/tb_ps2_key_event_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 key event path.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;
  localparam logic [7:0] PS2_CAPS   = 8'h58;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rep;
  } ps2_event_t;

  // Keyboard status bytes that carry no key information when seen outside a prefix.
  function automatic logic is_noise(input logic [7:0] b);
    return (b == PS2_ERR0) || (b == PS2_ERR1) || (b == PS2_BAT);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous FIFO holding decoded key events; simultaneous push/pop allowed when full.
module ps2_event_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 11
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// Turns PS/2 scan-code bytes into buffered key events with repeat, shift and caps tracking.
module ps2_key_event_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             rx_err,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_break,
  output logic             ev_repeat,
  output logic [8:0]       ascii_addr,
  output logic             shift,
  output logic             caps,
  output logic [CNT_W-1:0] press_cnt,
  output logic             ovf
);

  localparam int unsigned     TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  ps2_state_t       state_q, state_d;
  logic [TO_W-1:0]  to_cnt;
  logic             rx_acc;
  logic             fire, fire_ext, fire_brk, rep_c;
  ps2_event_t       ev_new, push_ev_q, head, head_vis;
  logic             push_q;
  logic [8:0]       held_key;
  logic             held_valid;
  logic             lshift, rshift, caps_q, ovf_q;
  logic [CNT_W-1:0] press_q;
  logic             fifo_full, fifo_empty, pop;

  assign rx_acc = rx_valid && !rx_err;

  always_comb begin
    state_d  = state_q;
    fire     = 1'b0;
    fire_ext = 1'b0;
    fire_brk = 1'b0;
    if (rx_valid && rx_err) begin
      state_d = ST_IDLE;
    end else if (rx_acc) begin
      if (rx_data == PS2_EXT) begin
        state_d = ST_EXT;
      end else if (rx_data == PS2_BRK) begin
        state_d = (state_q == ST_EXT || state_q == ST_EXT_BRK) ? ST_EXT_BRK : ST_BRK;
      end else if (state_q == ST_IDLE && is_noise(rx_data)) begin
        state_d = ST_IDLE;
      end else begin
        state_d  = ST_IDLE;
        fire     = 1'b1;
        fire_ext = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
        fire_brk = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
      end
    end else if (state_q != ST_IDLE && to_cnt == TO_LAST) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    rep_c       = !fire_brk && held_valid && (held_key == {fire_ext, rx_data});
    ev_new      = '0;
    ev_new.code = rx_data;
    ev_new.ext  = fire_ext;
    ev_new.brk  = fire_brk;
    ev_new.rep  = rep_c;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      to_cnt  <= '0;
    end else begin
      state_q <= state_d;
      if (rx_acc || state_d == ST_IDLE) to_cnt <= '0;
      else                              to_cnt <= to_cnt + 1'b1;
    end
  end

  // Key-state updates follow the decoded byte directly, independent of FIFO space.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      held_key   <= '0;
      held_valid <= 1'b0;
      press_q    <= '0;
      lshift     <= 1'b0;
      rshift     <= 1'b0;
      caps_q     <= 1'b0;
    end else if (fire) begin
      if (!fire_brk) begin
        if (!rep_c) begin
          held_key   <= {fire_ext, rx_data};
          held_valid <= 1'b1;
          press_q    <= press_q + 1'b1;
        end
      end else if (held_valid && held_key == {fire_ext, rx_data}) begin
        held_valid <= 1'b0;
      end
      if (!fire_ext) begin
        case (rx_data)
          PS2_LSHIFT: lshift <= !fire_brk;
          PS2_RSHIFT: rshift <= !fire_brk;
          PS2_CAPS:   if (!fire_brk && !rep_c) caps_q <= !caps_q;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      push_q    <= 1'b0;
      push_ev_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      push_q    <= fire;
      push_ev_q <= ev_new;
      if (push_q && fifo_full && !pop) ovf_q <= 1'b1;
    end
  end

  assign pop = ev_ready && !fifo_empty;

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(ps2_event_t))
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (push_q),
    .wr_data (push_ev_q),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Storage is unreset, so the head is masked while empty to keep outputs at zero.
  assign head_vis   = fifo_empty ? '0 : head;
  assign ev_valid   = !fifo_empty;
  assign ev_code    = head_vis.code;
  assign ev_ext     = head_vis.ext;
  assign ev_break   = head_vis.brk;
  assign ev_repeat  = head_vis.rep;
  assign ascii_addr = {head_vis.ext, head_vis.code};
  assign shift      = lshift | rshift;
  assign caps       = caps_q;
  assign press_cnt  = press_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Scoreboard bench for ps2_key_event_ctrl: expected events queued at stimulus time, checked at handshake.
module tb_ps2_key_event_ctrl;
  import ps2_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TO    = 16;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_err = 1'b0;
  logic       ev_valid, ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext, ev_break, ev_repeat;
  logic [8:0] ascii_addr;
  logic       shift, caps, ovf;
  logic [7:0] press_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  ps2_event_t exp_q[$];

  always #5 clk = ~clk;

  ps2_key_event_ctrl #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TO),
    .CNT_W       (8)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_err     (rx_err),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_code    (ev_code),
    .ev_ext     (ev_ext),
    .ev_break   (ev_break),
    .ev_repeat  (ev_repeat),
    .ascii_addr (ascii_addr),
    .shift      (shift),
    .caps       (caps),
    .press_cnt  (press_cnt),
    .ovf        (ovf)
  );

  // Scoreboard: every accepted event is compared against the oldest expectation.
  always @(negedge clk) begin
    ps2_event_t e;
    if (resetn && ev_valid && ev_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got code=%h ext=%b brk=%b rep=%b, required no event",
                 ev_code, ev_ext, ev_break, ev_repeat);
      end else begin
        e = exp_q.pop_front();
        if ({ev_code, ev_ext, ev_break, ev_repeat, ascii_addr} !== {e.code, e.ext, e.brk, e.rep, e.ext, e.code}) begin
          n_fail++;
          $display("FAIL event: got code=%h ext=%b brk=%b rep=%b addr=%h, required code=%h ext=%b brk=%b rep=%b addr=%h",
                   ev_code, ev_ext, ev_break, ev_repeat, ascii_addr, e.code, e.ext, e.brk, e.rep, {e.ext, e.code});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic ps2_event_t mk(input logic [7:0] c, input logic x, input logic b, input logic r);
    ps2_event_t e;
    e.code = c; e.ext = x; e.brk = b; e.rep = r;
    return e;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic err = 1'b0);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = b; rx_err = err;
    @(negedge clk);
    rx_valid = 1'b0; rx_data = '0; rx_err = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0; rx_valid = 1'b0; rx_err = 1'b0; ev_ready = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.delete();
    resetn = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d events still pending, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({ev_valid, ev_code, ev_ext, ev_break, ev_repeat, ascii_addr, shift, caps, press_cnt, ovf} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0",
               {ev_valid, ev_code, ev_ext, ev_break, ev_repeat, ascii_addr, shift, caps, press_cnt, ovf});
    end
  endtask

  task automatic test_basic();
    do_reset();
    exp_q.push_back(mk(8'h1C, 0, 0, 0));
    send_byte(8'h1C);
    n_checks++;
    if (ev_valid !== 1'b0) begin
      n_fail++; $display("FAIL latency_early: ev_valid=%b one cycle after byte, required 0", ev_valid);
    end
    @(negedge clk);
    n_checks++;
    if (ev_valid !== 1'b1) begin
      n_fail++; $display("FAIL latency_on_time: ev_valid=%b two cycles after byte, required 1", ev_valid);
    end
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'hAA);
    exp_q.push_back(mk(8'h1C, 0, 1, 0));
    send_byte(8'hF0); send_byte(8'h1C);
    wait_drain("basic");
    n_checks++;
    if (press_cnt !== 8'd1) begin
      n_fail++; $display("FAIL basic_press_cnt: got %0d, required 1", press_cnt);
    end
  endtask

  task automatic test_ext();
    do_reset();
    exp_q.push_back(mk(8'h75, 1, 0, 0));
    exp_q.push_back(mk(8'h75, 1, 1, 0));
    exp_q.push_back(mk(8'h75, 1, 0, 0));
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'h75);
    wait_drain("ext");
    n_checks++;
    if (press_cnt !== 8'd2) begin
      n_fail++; $display("FAIL ext_press_cnt: got %0d, required 2", press_cnt);
    end
  endtask

  task automatic test_typematic();
    do_reset();
    exp_q.push_back(mk(8'h1C, 0, 0, 0));
    exp_q.push_back(mk(8'h1C, 0, 0, 1));
    exp_q.push_back(mk(8'h1C, 0, 0, 1));
    exp_q.push_back(mk(8'h2A, 0, 1, 0));
    exp_q.push_back(mk(8'h1C, 0, 0, 1));
    exp_q.push_back(mk(8'h1C, 0, 1, 0));
    exp_q.push_back(mk(8'h1C, 0, 0, 0));
    send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h2A);
    send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'h1C);
    wait_drain("typematic");
    n_checks++;
    if (press_cnt !== 8'd2) begin
      n_fail++; $display("FAIL typematic_press_cnt: got %0d, required 2", press_cnt);
    end
  endtask

  task automatic test_modifiers();
    do_reset();
    exp_q.push_back(mk(8'h12, 0, 0, 0));
    send_byte(8'h12);
    exp_q.push_back(mk(8'h1C, 0, 0, 0));
    send_byte(8'h1C);
    wait_drain("lshift");
    n_checks++;
    if (shift !== 1'b1) begin
      n_fail++; $display("FAIL lshift_held: shift=%b, required 1", shift);
    end
    exp_q.push_back(mk(8'h12, 0, 1, 0));
    send_byte(8'hF0); send_byte(8'h12);
    wait_drain("lshift_rel");
    n_checks++;
    if (shift !== 1'b0) begin
      n_fail++; $display("FAIL lshift_released: shift=%b, required 0", shift);
    end
    exp_q.push_back(mk(8'h59, 0, 0, 0));
    send_byte(8'h59);
    wait_drain("rshift");
    n_checks++;
    if (shift !== 1'b1) begin
      n_fail++; $display("FAIL rshift_held: shift=%b, required 1", shift);
    end
    exp_q.push_back(mk(8'h59, 0, 1, 0));
    exp_q.push_back(mk(8'h12, 1, 0, 0));
    send_byte(8'hF0); send_byte(8'h59);
    send_byte(8'hE0); send_byte(8'h12);
    wait_drain("ext_shift");
    n_checks++;
    if (shift !== 1'b0) begin
      n_fail++; $display("FAIL ext_12_no_shift: shift=%b, required 0", shift);
    end
    exp_q.push_back(mk(8'h58, 0, 0, 0));
    exp_q.push_back(mk(8'h58, 0, 0, 1));
    send_byte(8'h58); send_byte(8'h58);
    wait_drain("caps_on");
    n_checks++;
    if (caps !== 1'b1) begin
      n_fail++; $display("FAIL caps_on_repeat_ignored: caps=%b, required 1", caps);
    end
    exp_q.push_back(mk(8'h58, 0, 1, 0));
    exp_q.push_back(mk(8'h58, 0, 0, 0));
    send_byte(8'hF0); send_byte(8'h58);
    send_byte(8'h58);
    wait_drain("caps_off");
    n_checks++;
    if (caps !== 1'b0) begin
      n_fail++; $display("FAIL caps_toggle_off: caps=%b, required 0", caps);
    end
    n_checks++;
    if (press_cnt !== 8'd6) begin
      n_fail++; $display("FAIL modifiers_press_cnt: got %0d, required 6", press_cnt);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] keys [5];
    keys = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    do_reset();
    ev_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < int'(DEPTH)) exp_q.push_back(mk(keys[i], 0, 0, 0));
      send_byte(keys[i]);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (ovf !== 1'b1) begin
      n_fail++; $display("FAIL overflow_flag: ovf=%b, required 1", ovf);
    end
    n_checks++;
    if (press_cnt !== 8'd5) begin
      n_fail++; $display("FAIL overflow_press_cnt: got %0d, required 5", press_cnt);
    end
    @(posedge clk); #1 ev_ready = 1'b1;
    wait_drain("overflow");
    n_checks++;
    if (ovf !== 1'b1) begin
      n_fail++; $display("FAIL overflow_sticky: ovf=%b, required 1", ovf);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] keys [5];
    keys = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    do_reset();
    ev_ready = 1'b0;
    for (int i = 0; i < 5; i++) exp_q.push_back(mk(keys[i], 0, 0, 0));
    for (int i = 0; i < 4; i++) send_byte(keys[i]);
    // Fifth push lands on a full FIFO in the same cycle the consumer starts popping.
    @(negedge clk);
    rx_valid = 1'b1; rx_data = keys[4];
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_data = '0; ev_ready = 1'b1;
    wait_drain("full_push_pop");
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++; $display("FAIL full_push_pop_ovf: ovf=%b, required 0", ovf);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    exp_q.push_back(mk(8'h1C, 0, 0, 0));
    send_byte(8'hF0);
    repeat (TO) @(negedge clk);
    send_byte(8'h1C);
    exp_q.push_back(mk(8'h1C, 0, 1, 0));
    send_byte(8'hF0);
    repeat (TO - 2) @(negedge clk);
    send_byte(8'h1C);
    exp_q.push_back(mk(8'h1C, 0, 0, 0));
    send_byte(8'hE0);
    send_byte(8'h75, 1'b1);
    send_byte(8'h1C);
    wait_drain("timeout_err");
  endtask

  task automatic test_reset_mid();
    do_reset();
    exp_q.push_back(mk(8'h12, 0, 0, 0));
    send_byte(8'h12);
    wait_drain("pre_reset");
    send_byte(8'hE0);
    resetn = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ev_valid, ev_code, ev_ext, ev_break, ev_repeat, ascii_addr, shift, caps, press_cnt, ovf} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %h, required 0",
               {ev_valid, ev_code, ev_ext, ev_break, ev_repeat, ascii_addr, shift, caps, press_cnt, ovf});
    end
    resetn = 1'b1;
    exp_q.push_back(mk(8'h75, 0, 0, 0));
    send_byte(8'h75);
    wait_drain("post_reset");
  endtask

  initial begin
    ev_ready = 1'b1;
    test_reset();
    test_basic();
    test_ext();
    test_typematic();
    test_modifiers();
    test_overflow();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
